// File: rtl/jt900h_wrctl.sv
// JT900H store controller: splits byte/word/long stores into 16-bit RAM write beats.
// Define JT900H_WRBUF_EN to add a one-entry request buffer for back-to-back stores.
module jt900h_wrctl #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [1:0]    wr_size,
    output logic          wr_ack,
    output logic          busy,
    output logic          wr_done,
    output logic [AW-1:0] ram_waddr,
    output logic [15:0]   ram_din,
    output logic [1:0]    ram_we
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state_q, state_d;
    logic [47:0]   sreg_q, sreg_d;
    logic [5:0]    msk_q, msk_d;
    logic [AW-1:0] wa_q, wa_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [15:0]   din_q, din_d;
    logic [1:0]    we_q, we_d;

    // Request that would be loaded into the beat registers this cycle
    logic [AW-1:0] rq_addr;
    logic [31:0]   rq_data;
    logic [1:0]    rq_size;
    logic [3:0]    size_mask;
    logic [47:0]   ld_sreg;
    logic [5:0]    ld_msk;
    logic [AW-1:0] ld_wa;

`ifdef JT900H_WRBUF_EN
    logic          buf_v_q, buf_v_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic [1:0]    buf_size_q, buf_size_d;

    assign rq_addr = buf_v_q ? buf_addr_q : wr_addr;
    assign rq_data = buf_v_q ? buf_data_q : wr_data;
    assign rq_size = buf_v_q ? buf_size_q : wr_size;
`else
    assign rq_addr = wr_addr;
    assign rq_data = wr_data;
    assign rq_size = wr_size;
`endif

    always_comb begin
        case (rq_size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            2'd2:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;  // reserved size: one silent beat
        endcase
    end

    // Odd addresses push every byte up one lane
    assign ld_sreg = rq_addr[0] ? {8'b0, rq_data, 8'b0} : {16'b0, rq_data};
    assign ld_msk  = rq_addr[0] ? {1'b0, size_mask, 1'b0} : {2'b0, size_mask};
    assign ld_wa   = {rq_addr[AW-1:1], 1'b0};

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        msk_d   = msk_q;
        wa_d    = wa_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        waddr_d = waddr_q;
        din_d   = din_q;
        we_d    = 2'b00;
`ifdef JT900H_WRBUF_EN
        buf_v_d    = buf_v_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_size_d = buf_size_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // busy_q still high means the cycle right after the last beat
                if (wr_en && !busy_q) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    sreg_d  = ld_sreg;
                    msk_d   = ld_msk;
                    wa_d    = ld_wa;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                waddr_d = wa_q;
                din_d   = sreg_q[15:0];
                we_d    = msk_q[1:0];
                sreg_d  = sreg_q >> 16;
                msk_d   = msk_q >> 2;
                wa_d    = wa_q + AW'(2);
                if (msk_q[5:2] == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef JT900H_WRBUF_EN
                    if (buf_v_q || wr_en) begin
                        ack_d   = !buf_v_q;
                        buf_v_d = 1'b0;
                        sreg_d  = ld_sreg;
                        msk_d   = ld_msk;
                        wa_d    = ld_wa;
                        state_d = WRITE;
                    end
                end else if (wr_en && !buf_v_q) begin
                    ack_d      = 1'b1;
                    buf_v_d    = 1'b1;
                    buf_addr_d = wr_addr;
                    buf_data_d = wr_data;
                    buf_size_d = wr_size;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            msk_q   <= '0;
            wa_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            we_q    <= '0;
`ifdef JT900H_WRBUF_EN
            buf_v_q    <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_size_q <= '0;
`endif
        end else if (cen) begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            msk_q   <= msk_d;
            wa_q    <= wa_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            we_q    <= we_d;
`ifdef JT900H_WRBUF_EN
            buf_v_q    <= buf_v_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_size_q <= buf_size_d;
`endif
        end
    end

    assign wr_ack    = ack_q;
    assign busy      = busy_q;
    assign wr_done   = done_q;
    assign ram_waddr = waddr_q;
    assign ram_din   = din_q;
    assign ram_we    = we_q;

endmodule

// File: tb/tb_jt900h_wrctl.sv
// Directed bench for jt900h_wrctl: beat splitting, alignment, wrap, cen stalls,
// reset abort and back-to-back requests (buffered or not, following JT900H_WRBUF_EN).
module tb_jt900h_wrctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_size;
    logic        wr_ack;
    logic        busy;
    logic        wr_done;
    logic [23:0] ram_waddr;
    logic [15:0] ram_din;
    logic [1:0]  ram_we;

    int n_checks = 0;
    int n_errors = 0;

    jt900h_wrctl #(.AW(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_size   (wr_size),
        .wr_ack    (wr_ack),
        .busy      (busy),
        .wr_done   (wr_done),
        .ram_waddr (ram_waddr),
        .ram_din   (ram_din),
        .ram_we    (ram_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [23:0] a, input logic [31:0] d,
                         input logic [1:0] s);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        wr_size = s;
    endtask

    task automatic start(input string tag, input logic [23:0] a, input logic [31:0] d,
                         input logic [1:0] s);
        drive(1'b1, a, d, s);
        tick();
        check({tag, " ack"}, 64'(wr_ack), 64'd1);
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " we@ack"}, 64'(ram_we), 64'd0);
        wr_en = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [23:0] a, input logic [15:0] din,
                        input logic [1:0] we, input logic last);
        check({tag, " waddr"}, 64'(ram_waddr), 64'(a));
        check({tag, " din"}, 64'(ram_din), 64'(din));
        check({tag, " we"}, 64'(ram_we), 64'(we));
        check({tag, " done"}, 64'(wr_done), 64'(last));
        check({tag, " busy"}, 64'(busy), 64'd1);
    endtask

    task automatic idle(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " we"}, 64'(ram_we), 64'd0);
        check({tag, " done"}, 64'(wr_done), 64'd0);
        check({tag, " ack"}, 64'(wr_ack), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        cen = 1'b0;
        drive(1'b0, 24'h0, 32'h0, 2'd0);
        tick();
        tick();
        idle("reset");
        check("reset waddr", 64'(ram_waddr), 64'd0);
        check("reset din", 64'(ram_din), 64'd0);
        rst = 1'b0;
        cen = 1'b1;
        tick();

        // Byte at odd address: upper lane only
        start("byte", 24'h001235, 32'h000000AB, 2'd0);
        tick(); beat("byte b1", 24'h001234, 16'hAB00, 2'b10, 1'b1);
        tick(); idle("byte end");

        // Word at odd address straddles two words
        start("word", 24'h000101, 32'h00001234, 2'd1);
        tick(); beat("word b1", 24'h000100, 16'h3400, 2'b10, 1'b0);
        tick(); beat("word b2", 24'h000102, 16'h0012, 2'b01, 1'b1);
        tick(); idle("word end");

        // Aligned long
        start("long", 24'h000200, 32'h89ABCDEF, 2'd2);
        tick(); beat("long b1", 24'h000200, 16'hCDEF, 2'b11, 1'b0);
        tick(); beat("long b2", 24'h000202, 16'h89AB, 2'b11, 1'b1);
        tick(); idle("long end");

        // Odd long at the top of memory wraps to address 0
        start("wrap", 24'hFFFFFF, 32'h11223344, 2'd2);
        tick(); beat("wrap b1", 24'hFFFFFE, 16'h4400, 2'b10, 1'b0);
        tick(); beat("wrap b2", 24'h000000, 16'h2233, 2'b11, 1'b0);
        tick(); beat("wrap b3", 24'h000002, 16'h0011, 2'b01, 1'b1);
        tick(); idle("wrap end");

        // Reserved size: one beat with no lanes enabled
        start("rsv", 24'h000300, 32'h00000000, 2'd3);
        tick();
        check("rsv we", 64'(ram_we), 64'd0);
        check("rsv done", 64'(wr_done), 64'd1);
        tick(); idle("rsv end");

        // cen alternating: everything freezes on cen=0 cycles
        start("cen", 24'h000400, 32'hDEADBEEF, 2'd2);
        cen = 1'b0; tick();
        check("cen hold ack", 64'(wr_ack), 64'd1);
        check("cen hold we", 64'(ram_we), 64'd0);
        cen = 1'b1; tick(); beat("cen b1", 24'h000400, 16'hBEEF, 2'b11, 1'b0);
        cen = 1'b0; tick(); beat("cen b1 hold", 24'h000400, 16'hBEEF, 2'b11, 1'b0);
        cen = 1'b1; tick(); beat("cen b2", 24'h000402, 16'hDEAD, 2'b11, 1'b1);
        cen = 1'b0; tick(); beat("cen b2 hold", 24'h000402, 16'hDEAD, 2'b11, 1'b1);
        cen = 1'b1; tick(); idle("cen end");

        // Reset mid-store abandons the remaining beats, even with cen low
        start("abort", 24'h000501, 32'h55667788, 2'd2);
        tick(); beat("abort b1", 24'h000500, 16'h8800, 2'b10, 1'b0);
        rst = 1'b1; cen = 1'b0; tick();
        idle("abort rst");
        rst = 1'b0; cen = 1'b1;
        tick(); idle("abort after1");
        tick(); idle("abort after2");

        // Second request held while the first is still writing
        start("b2b1", 24'h000600, 32'hAAAA5555, 2'd2);
        drive(1'b1, 24'h000701, 32'h0000BEEF, 2'd1);
`ifdef JT900H_WRBUF_EN
        tick(); beat("b2b1 b1", 24'h000600, 16'h5555, 2'b11, 1'b0);
        check("b2b buffered ack", 64'(wr_ack), 64'd1);
        wr_en = 1'b0;
        tick(); beat("b2b1 b2", 24'h000602, 16'hAAAA, 2'b11, 1'b1);
        check("b2b b2 ack", 64'(wr_ack), 64'd0);
        tick(); beat("b2b2 b1", 24'h000700, 16'hEF00, 2'b10, 1'b0);
        tick(); beat("b2b2 b2", 24'h000702, 16'h00BE, 2'b01, 1'b1);
        tick(); idle("b2b end");
`else
        tick(); beat("b2b1 b1", 24'h000600, 16'h5555, 2'b11, 1'b0);
        check("b2b b1 ack", 64'(wr_ack), 64'd0);
        tick(); beat("b2b1 b2", 24'h000602, 16'hAAAA, 2'b11, 1'b1);
        check("b2b b2 ack", 64'(wr_ack), 64'd0);
        tick(); idle("b2b gap");
        tick();
        check("b2b late ack", 64'(wr_ack), 64'd1);
        check("b2b late busy", 64'(busy), 64'd1);
        wr_en = 1'b0;
        tick(); beat("b2b2 b1", 24'h000700, 16'hEF00, 2'b10, 1'b0);
        tick(); beat("b2b2 b2", 24'h000702, 16'h00BE, 2'b01, 1'b1);
        tick(); idle("b2b end");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jt900h_wrctl.md
Name: jt900h_wrctl

Overview:
- Write-side memory controller for the JT900H core. It is the store counterpart of the read-only fetch/load path that drives ram_addr and consumes ram_dout.
- Takes a byte/word/long store request (24-bit byte address, 32-bit data) from the control unit. Splits it into one to three 16-bit bus write beats with per-byte lane enables.
- Handles odd alignment and 24-bit address wrap.
- Sits between jt900h_ctrl (requester) and the external RAM write port.

Parameters:
- AW, 24, byte address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cen  input  1  clock enable; all state advances only on clk edges with cen=1
- wr_en  input  1  store request; level, sampled on cen edges
- wr_addr  input  AW  byte address of least-significant byte
- wr_data  input  32  store data, little-endian; unused upper bytes ignored
- wr_size  input  2  0=byte, 1=word, 2=long, 3=reserved
- wr_ack  output  1  one-cen-cycle pulse: request accepted
- busy  output  1  high while a store is in progress
- wr_done  output  1  one-cen-cycle pulse, coincident with the last beat
- ram_waddr  output  AW  word-aligned byte address, bit 0 always 0
- ram_din  output  16  write data; [7:0] goes to the even byte, [15:8] to the odd byte
- ram_we  output  2  lane enables; [0]=even byte, [1]=odd byte

Behaviour:
- Reset (rst=1 at a clk edge, cen ignored):
  - state=IDLE.
  - Outputs wr_ack, busy, wr_done, ram_we = 0.
  - ram_waddr = 0, ram_din = 0.
  - An in-flight store is abandoned with no further beats; the buffer (if present) is cleared.
- States: IDLE, WRITE.
- IDLE, cen=1, wr_en=1:
  - Assert wr_ack for that one cen cycle.
  - Load the shift register: sreg[47:0] = {16'b0, wr_data} << (8*wr_addr[0]).
  - Load the mask register: msk[5:0] = size_mask << wr_addr[0], where size_mask = 0001 for byte, 0011 for word, 1111 for long.
  - Load the address: wa = {wr_addr[AW-1:1], 1'b0}.
  - busy=1; go to WRITE.
- wr_size=3: acknowledged and loaded with msk=0. The controller spends one WRITE cycle with ram_we=0, then pulses wr_done. No RAM write occurs.
- WRITE, each cen=1 cycle (registered outputs):
  - ram_waddr = wa, ram_din = sreg[15:0], ram_we = msk[1:0].
  - Then shift: sreg >>= 16, msk >>= 2, wa += 2 (modulo 2^AW, so 0xFFFFFE wraps to 0x000000).
  - If the shifted msk == 0: this beat is the last. Assert wr_done with it; the next cen cycle returns to IDLE with busy=0 and ram_we=0.
- Beat count: byte = 1; word = 1 (even) or 2 (odd); long = 2 (even) or 3 (odd).
- Latency: the first beat appears on the cen cycle after wr_ack. Busy-to-idle is beats+1 cen cycles.
- When cen=0, all outputs hold, including the ram_we and wr_done pulses. The RAM must qualify writes with cen.
- A wr_en arriving while busy is not acknowledged. The requester holds wr_en until it sees wr_ack.
- Outside WRITE, ram_we is always 0.

Optional Feature:
- Macro: JT900H_WRBUF_EN.
- With the macro: a one-entry request buffer is added.
  - A wr_en during WRITE with the buffer empty is captured and wr_ack pulses immediately.
  - On the cen cycle after the last beat, the buffered request starts with no IDLE gap: its first beat follows directly, and busy stays 1.
  - Buffer full plus new wr_en: no ack.
  - Reset clears the buffer.
- Without the macro: no buffer. Behaviour is exactly as above; a new store always needs at least one IDLE cen cycle between stores.

Test Plan:
- Byte store, addr 0x001235, data 0x000000AB → 1 beat:
  - ram_waddr=0x001234, ram_din[15:8]=0xAB, ram_we=2'b10.
  - wr_done on the same cycle.
- Word store, odd addr 0x000101, data 0x00001234 → 2 beats:
  - Beat 1: 0x000100, din[15:8]=0x34, we=10.
  - Beat 2: 0x000102, din[7:0]=0x12, we=01.
- Long store, even addr 0x000200, data 0x89ABCDEF → 2 beats:
  - Beat 1: (0x200, 0xCDEF, 11).
  - Beat 2: (0x202, 0x89AB, 11).
- Long store, addr 0xFFFFFF, data 0x11223344 → 3 beats with wrap:
  - Beat 1: (0xFFFFFE, din[15:8]=0x44, we=10).
  - Beat 2: (0x000000, 0x2233, 11).
  - Beat 3: (0x000002, din[7:0]=0x11, we=01).
- cen toggling 1/0 during a long store: outputs frozen while cen=0; same beat sequence. rst asserted mid-store: ram_we=0 and busy=0 on the next clk, with no further beats.
- Second wr_en held during a busy store:
  - Without JT900H_WRBUF_EN: ack only after the IDLE cycle.
  - With JT900H_WRBUF_EN: ack the cycle it is sampled, and back-to-back beats with busy never dropping.
